// File: rtl/div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
//
// Shared definitions for the division sequencer and its sign-fix helper.
//   - state_e        : sequencer FSM states (IDLE, START, RUN, FIX)
//   - DEFAULT_WIDTH  : default operand/result width
//   - DIV0_LO_BIT    : fill bit of the LO value written on divide-by-zero
//                      (LO = {WIDTH{DIV0_LO_BIT}}, i.e. all ones)
//
// Configuration macro: DIV_SIGNED_EN (consumed by the files that import this
// package; the package itself is identical in both builds).
// ---------------------------------------------------------------------------
package div_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Encodings are fixed so the state register reads the same in every tool.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FIX   = 2'd3
    } state_e;

    // LO on divide-by-zero is all ones at any WIDTH; expressed as a fill bit
    // so the replication width follows the instantiating module's WIDTH.
    localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/div_sequencer_sign_fix.sv
// ---------------------------------------------------------------------------
// div_sign_fix
//
// Combinational sign handling for DIV (signed) operations. Only compiled when
// DIV_SIGNED_EN is defined; the unsigned-only build has no sign logic at all.
//
// Ports:
//   op_signed   in   1      1 = DIV, 0 = DIVU (no conversion)
//   op_a        in   WIDTH  raw dividend
//   op_b        in   WIDTH  raw divisor
//   mag_a       out  WIDTH  |op_a| as unsigned WIDTH bits
//   mag_b       out  WIDTH  |op_b| as unsigned WIDTH bits
//   neg_quot    out  1      quotient must be negated (sign(a) ^ sign(b))
//   neg_rem     out  1      remainder must be negated (sign(a))
//   fix_quot    in   1      registered neg_quot for the result in flight
//   fix_rem     in   1      registered neg_rem for the result in flight
//   res_quot    in   WIDTH  unsigned quotient from the divider
//   res_rem     in   WIDTH  unsigned remainder from the divider
//   quot_fixed  out  WIDTH  sign-corrected quotient
//   rem_fixed   out  WIDTH  sign-corrected remainder
// ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
module div_sign_fix
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_quot,
    output logic             neg_rem,
    input  logic             fix_quot,
    input  logic             fix_rem,
    input  logic [WIDTH-1:0] res_quot,
    input  logic [WIDTH-1:0] res_rem,
    output logic [WIDTH-1:0] quot_fixed,
    output logic [WIDTH-1:0] rem_fixed
);

    logic sign_a;
    logic sign_b;

    assign sign_a = op_signed & op_a[WIDTH-1];
    assign sign_b = op_signed & op_b[WIDTH-1];

    // Two's-complement negation on WIDTH bits: the most negative value maps
    // onto itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1).
    assign mag_a = sign_a ? ({WIDTH{1'b0}} - op_a) : op_a;
    assign mag_b = sign_b ? ({WIDTH{1'b0}} - op_b) : op_b;

    assign neg_quot = sign_a ^ sign_b;
    assign neg_rem  = sign_a;

    // The overflow case -2^(WIDTH-1) / -1 needs no special path: both signs
    // are set, the quotient is not negated and 2^(WIDTH-1) wraps naturally.
    assign quot_fixed = fix_quot ? ({WIDTH{1'b0}} - res_quot) : res_quot;
    assign rem_fixed  = fix_rem  ? ({WIDTH{1'b0}} - res_rem)  : res_rem;

endmodule
`endif

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//
// Issues DIV/DIVU requests from the multi-cycle control unit onto the shared
// shift-subtract divider. Owns the iteration counter that terminates the
// divider controller, converts operand signs, handles divide-by-zero without
// starting the divider, writes quotient/remainder into LO/HI, and stalls
// MFHI/MFLO while a division is in flight.
//
// Configuration macro: DIV_SIGNED_EN
//   defined   : op_signed selects DIV (signed) or DIVU (unsigned).
//   undefined : every operation is DIVU; op_signed is ignored, operands and
//               results pass through without sign logic.
//
// Ports:
//   CLK            in   1      clock
//   RST            in   1      synchronous active-high reset
//   op_valid       in   1      division request (held until accepted)
//   op_signed      in   1      1 = DIV, 0 = DIVU
//   op_a           in   WIDTH  dividend
//   op_b           in   WIDTH  divisor
//   op_ready       out  1      high only in IDLE; accept = op_valid & op_ready
//   mf_req         in   1      MFHI/MFLO in decode
//   stall          out  1      mf_req & busy
//   busy           out  1      sequencer not idle
//   div_start      out  1      one-cycle start pulse to divider controller
//   div_done       out  1      terminate/flush to divider controller
//   div_dividend   out  WIDTH  dividend magnitude, registered at accept
//   div_divisor    out  WIDTH  divisor magnitude, registered at accept
//   div_quotient   in   WIDTH  divider quotient (unsigned)
//   div_remainder  in   WIDTH  divider remainder (unsigned)
//   hi             out  WIDTH  HI register (remainder)
//   lo             out  WIDTH  LO register (quotient)
//
// Cycle budget of a normal division (accept = cycle 0):
//   START at 1, RUN at 2..WIDTH+2, FIX at WIDTH+3, results from WIDTH+4.
// Divide-by-zero: FIX at 1, results from 2.
// ---------------------------------------------------------------------------
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    input  logic             mf_req,
    output logic             stall,
    output logic             busy,
    output logic             div_start,
    output logic             div_done,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             zero_q,     zero_d;

    // -----------------------------------------------------------------------
    // Sign conversion
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_quot_in;
    logic             neg_rem_in;
    logic [WIDTH-1:0] rem_raw;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // On divide-by-zero HI must hold the original dividend. The stored
    // magnitude is sent through the remainder path: the remainder sign flag
    // equals sign(a), so the negation there restores the raw op_a.
    assign rem_raw = zero_q ? dividend_q : div_remainder;

`ifdef DIV_SIGNED_EN
    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op_signed  (op_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg_quot   (neg_quot_in),
        .neg_rem    (neg_rem_in),
        .fix_quot   (neg_quot_q),
        .fix_rem    (neg_rem_q),
        .res_quot   (div_quotient),
        .res_rem    (rem_raw),
        .quot_fixed (quot_fixed),
        .rem_fixed  (rem_fixed)
    );
`else
    // Unsigned-only build: operands and results pass straight through and
    // the sign flags stay at zero.
    assign mag_a       = op_a;
    assign mag_b       = op_b;
    assign neg_quot_in = 1'b0;
    assign neg_rem_in  = 1'b0;
    assign quot_fixed  = div_quotient;
    assign rem_fixed   = rem_raw;

    logic unused_sign_bits;
    assign unused_sign_bits = op_signed ^ neg_quot_q ^ neg_rem_q;
`endif

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        op_ready   = 1'b0;
        div_start  = 1'b0;
        div_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                // Held high while idle so a divider controller left in OPER
                // by an aborted division (its reset is not RST) is flushed.
                div_done = 1'b1;
                if (op_valid) begin
                    dividend_d = mag_a;
                    divisor_d  = mag_b;
                    neg_quot_d = neg_quot_in;
                    neg_rem_d  = neg_rem_in;
                    zero_d     = (op_b == '0);
                    state_d    = (op_b == '0) ? FIX : START;
                end
            end

            START: begin
                div_start = 1'b1;
                cnt_d     = CNT_W'(WIDTH);
                state_d   = RUN;
            end

            // WIDTH+1 cycles: the divider's INIT cycle plus WIDTH OPER steps.
            RUN: begin
                if (cnt_q == '0) begin
                    div_done = 1'b1;
                    state_d  = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            FIX: begin
                hi_d    = rem_fixed;
                lo_d    = zero_q ? {WIDTH{DIV0_LO_BIT}} : quot_fixed;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments only, so every register samples the
        // pre-edge values regardless of statement order.
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy         = (state_q != IDLE);
    assign stall        = mf_req & busy;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
//
// Directed bench for div_sequencer. The divider datapath is stood in for by
// the bench: each scenario drives div_quotient/div_remainder with the
// hand-computed unsigned result for the magnitudes the sequencer should
// present. Expected values depend on DIV_SIGNED_EN where noted.
// Cycle 0 is the cycle in which op_valid is accepted; outputs are sampled on
// the falling edge of each cycle.
// ---------------------------------------------------------------------------
module tb_div_sequencer;

    localparam int WIDTH = 32;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             op_valid;
    logic             op_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ready;
    logic             mf_req;
    logic             stall;
    logic             busy;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_op.
    int   ob_start_cyc, ob_start_cnt, ob_done_cyc, ob_done_cnt, ob_idle_cyc;
    int   ob_stall_first, ob_stall_last;
    logic ob_stall_idle;

    div_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .op_valid      (op_valid),
        .op_signed     (op_signed),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_ready      (op_ready),
        .mf_req        (mf_req),
        .stall         (stall),
        .busy          (busy),
        .div_start     (div_start),
        .div_done      (div_done),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 CLK = ~CLK;

    // Issue one operation at the current (idle) cycle and follow it until
    // busy drops, returning at the falling edge of that first idle cycle.
    // mf_from > 0 raises mf_req from that cycle on.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sgn, input logic [WIDTH-1:0] q,
                          input logic [WIDTH-1:0] r, input int mf_from);
        op_valid = 1'b1; op_signed = sgn; op_a = a; op_b = b;
        div_quotient = q; div_remainder = r;
        ob_start_cyc = -1; ob_start_cnt = 0; ob_done_cyc = -1; ob_done_cnt = 0;
        ob_idle_cyc = -1; ob_stall_first = -1; ob_stall_last = -1; ob_stall_idle = 1'bx;
        @(posedge CLK); #1;
        op_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge CLK);
            if (div_start) begin
                ob_start_cnt++;
                if (ob_start_cyc < 0) ob_start_cyc = c;
            end
            if (div_done && busy) begin
                ob_done_cnt++;
                if (ob_done_cyc < 0) ob_done_cyc = c;
            end
            if (stall) begin
                if (ob_stall_first < 0) ob_stall_first = c;
                ob_stall_last = c;
            end
            if (!busy) begin
                ob_idle_cyc   = c;
                ob_stall_idle = stall;
                break;
            end
            if (mf_from > 0 && c + 1 == mf_from) mf_req = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; mf_req = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_vec++; if (hi !== '0) begin n_err++; $display("FAIL rst_hi: got %h want 0", hi); end
        n_vec++; if (lo !== '0) begin n_err++; $display("FAIL rst_lo: got %h want 0", lo); end
        n_vec++; if (div_dividend !== '0) begin n_err++; $display("FAIL rst_dividend: got %h want 0", div_dividend); end
        n_vec++; if (div_divisor !== '0) begin n_err++; $display("FAIL rst_divisor: got %h want 0", div_divisor); end
        n_vec++; if ({div_start, div_done, busy, op_ready, stall} !== 5'b01010) begin
            n_err++; $display("FAIL rst_ctrl: start/done/busy/ready/stall got %b want 01010",
                              {div_start, div_done, busy, op_ready, stall});
        end
        RST = 1'b0; mf_req = 1'b0;
    endtask

    task automatic test_divu_basic();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);
        n_vec++; if (ob_start_cyc !== 1) begin n_err++; $display("FAIL divu_start_cyc: got %0d want 1", ob_start_cyc); end
        n_vec++; if (ob_start_cnt !== 1) begin n_err++; $display("FAIL divu_start_cnt: got %0d want 1", ob_start_cnt); end
        n_vec++; if (ob_done_cyc !== 34) begin n_err++; $display("FAIL divu_done_cyc: got %0d want 34", ob_done_cyc); end
        n_vec++; if (ob_done_cnt !== 1) begin n_err++; $display("FAIL divu_done_cnt: got %0d want 1", ob_done_cnt); end
        n_vec++; if (ob_idle_cyc !== 36) begin n_err++; $display("FAIL divu_idle_cyc: got %0d want 36", ob_idle_cyc); end
        n_vec++; if (div_dividend !== 32'd100) begin n_err++; $display("FAIL divu_dividend: got %h want 64", div_dividend); end
        n_vec++; if (div_divisor !== 32'd7) begin n_err++; $display("FAIL divu_divisor: got %h want 7", div_divisor); end
        n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want e", lo); end
        n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h want 2", hi); end
        n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL divu_ready_idle: got %b want 1", op_ready); end
    endtask

    task automatic test_mf_stall();
        run_op(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 3);
        n_vec++; if (ob_stall_first !== 3) begin n_err++; $display("FAIL stall_first: got %0d want 3", ob_stall_first); end
        n_vec++; if (ob_stall_last !== 35) begin n_err++; $display("FAIL stall_last: got %0d want 35", ob_stall_last); end
        n_vec++; if (ob_stall_idle !== 1'b0) begin n_err++; $display("FAIL stall_at_36: got %b want 0", ob_stall_idle); end
        n_vec++; if ({hi, lo} !== {32'd2, 32'd22}) begin n_err++; $display("FAIL stall_hilo: got %h_%h want 2_16", hi, lo); end
        mf_req = 1'b0;
    endtask

    task automatic test_div_by_zero();
        run_op(32'd5, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
        n_vec++; if (ob_start_cnt !== 0) begin n_err++; $display("FAIL dz_start_cnt: got %0d want 0", ob_start_cnt); end
        n_vec++; if (ob_idle_cyc !== 2) begin n_err++; $display("FAIL dz_idle_cyc: got %0d want 2", ob_idle_cyc); end
        n_vec++; if (hi !== 32'd5) begin n_err++; $display("FAIL dz_hi: got %h want 5", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo: got %h want ffffffff", lo); end
        // Negative dividend over zero: HI must be the raw op_a in both builds.
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'h1234_5678, 32'h8765_4321, 0);
        n_vec++; if (ob_start_cnt !== 0) begin n_err++; $display("FAIL dzs_start_cnt: got %0d want 0", ob_start_cnt); end
        n_vec++; if (div_dividend !== (SGN ? 32'd5 : 32'hFFFF_FFFB)) begin
            n_err++; $display("FAIL dzs_dividend: got %h want %h", div_dividend, SGN ? 32'd5 : 32'hFFFF_FFFB);
        end
        n_vec++; if (hi !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL dzs_hi: got %h want fffffffb", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dzs_lo: got %h want ffffffff", lo); end
    endtask

    // -7 / 2: signed gives q=-3, r=-1; unsigned treats 0xFFFFFFF9 / 2.
    task automatic test_signed_neg_dividend();
        logic [WIDTH-1:0] e_dvd, e_lo, e_hi;
        e_dvd = SGN ? 32'd7 : 32'hFFFF_FFF9;
        e_lo  = SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
        e_hi  = SGN ? 32'hFFFF_FFFF : 32'h0000_0001;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, SGN ? 32'd3 : 32'h7FFF_FFFC, 32'd1, 0);
        n_vec++; if (div_dividend !== e_dvd) begin n_err++; $display("FAIL sna_dividend: got %h want %h", div_dividend, e_dvd); end
        n_vec++; if (lo !== e_lo) begin n_err++; $display("FAIL sna_lo: got %h want %h", lo, e_lo); end
        n_vec++; if (hi !== e_hi) begin n_err++; $display("FAIL sna_hi: got %h want %h", hi, e_hi); end
    endtask

    // 7 / -2: signed gives q=-3, r=1; unsigned gives q=0, r=7.
    task automatic test_signed_neg_divisor();
        logic [WIDTH-1:0] e_dvs, e_lo, e_hi;
        e_dvs = SGN ? 32'd2 : 32'hFFFF_FFFE;
        e_lo  = SGN ? 32'hFFFF_FFFD : 32'd0;
        e_hi  = SGN ? 32'd1 : 32'd7;
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, SGN ? 32'd3 : 32'd0, SGN ? 32'd1 : 32'd7, 0);
        n_vec++; if (div_divisor !== e_dvs) begin n_err++; $display("FAIL snb_divisor: got %h want %h", div_divisor, e_dvs); end
        n_vec++; if (lo !== e_lo) begin n_err++; $display("FAIL snb_lo: got %h want %h", lo, e_lo); end
        n_vec++; if (hi !== e_hi) begin n_err++; $display("FAIL snb_hi: got %h want %h", hi, e_hi); end
    endtask

    // -2^31 / -1 wraps to 0x80000000 with zero remainder when signed.
    task automatic test_signed_overflow();
        logic [WIDTH-1:0] e_dvd, e_dvs, e_lo, e_hi;
        e_dvd = 32'h8000_0000;
        e_dvs = SGN ? 32'd1 : 32'hFFFF_FFFF;
        e_lo  = SGN ? 32'h8000_0000 : 32'd0;
        e_hi  = SGN ? 32'd0 : 32'h8000_0000;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e_lo, e_hi, 0);
        n_vec++; if (div_dividend !== e_dvd) begin n_err++; $display("FAIL ovf_dividend: got %h want %h", div_dividend, e_dvd); end
        n_vec++; if (div_divisor !== e_dvs) begin n_err++; $display("FAIL ovf_divisor: got %h want %h", div_divisor, e_dvs); end
        n_vec++; if (lo !== e_lo) begin n_err++; $display("FAIL ovf_lo: got %h want %h", lo, e_lo); end
        n_vec++; if (hi !== e_hi) begin n_err++; $display("FAIL ovf_hi: got %h want %h", hi, e_hi); end
    endtask

    // DIVU with a negative-looking operand is unsigned in every build.
    task automatic test_divu_ignores_sign();
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 0);
        n_vec++; if (div_dividend !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL du_dividend: got %h want fffffff9", div_dividend); end
        n_vec++; if (lo !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL du_lo: got %h want 7ffffffc", lo); end
        n_vec++; if (hi !== 32'd1) begin n_err++; $display("FAIL du_hi: got %h want 1", hi); end
    endtask

    task automatic test_back_to_back();
        int ready_seen;
        ready_seen = 0;
        op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
        div_quotient = 32'd14; div_remainder = 32'd2;
        @(posedge CLK); #1;
        op_valid = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            @(negedge CLK);
            if (c >= 5 && c <= 35 && op_ready) ready_seen++;
            if (c == 36) begin
                n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready36: got %b want 1", op_ready); end
                n_vec++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL b2b_first: got %h_%h want 2_e", hi, lo); end
                div_quotient = 32'h0FFF_FFFF; div_remainder = 32'h0000_000F;
            end
            if (c == 37) begin
                op_valid = 1'b0;
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy37: got %b want 1", busy); end
                n_vec++; if (div_dividend !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_dividend: got %h want ffffffff", div_dividend); end
            end
            if (c == 71) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy71: got %b want 1", busy); end
            end
            if (c == 72) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy72: got %b want 0", busy); end
                n_vec++; if ({hi, lo} !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
                    n_err++; $display("FAIL b2b_second: got %h_%h want 0000000f_0fffffff", hi, lo);
                end
            end
            if (c == 5) begin
                op_valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0010;
            end
        end
        n_vec++; if (ready_seen !== 0) begin n_err++; $display("FAIL b2b_ready_busy: got %0d ready cycles want 0", ready_seen); end
    endtask

    task automatic test_reset_mid_run();
        op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd50; op_b = 32'd5;
        div_quotient = 32'd10; div_remainder = 32'd0;
        @(posedge CLK); #1;
        op_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            if (c == 10) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmr_busy10: got %b want 1", busy); end
                n_vec++; if (hi !== 32'h0000_000F) begin n_err++; $display("FAIL rmr_hi_kept: got %h want f", hi); end
                RST = 1'b1;
            end
            if (c == 11) begin
                n_vec++; if ({busy, op_ready, div_done} !== 3'b011) begin
                    n_err++; $display("FAIL rmr_ctrl11: busy/ready/done got %b want 011", {busy, op_ready, div_done});
                end
                n_vec++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rmr_cleared: got %h_%h want 0_0", hi, lo); end
                RST = 1'b0;
            end
        end
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);
        n_vec++; if (ob_idle_cyc !== 36) begin n_err++; $display("FAIL rmr_idle_cyc: got %0d want 36", ob_idle_cyc); end
        n_vec++; if (lo !== 32'd3) begin n_err++; $display("FAIL rmr_lo: got %h want 3", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rmr_hi: got %h want 0", hi); end
    endtask

    initial begin
        RST = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
        mf_req = 1'b0; div_quotient = '0; div_remainder = '0;
        test_reset();
        test_divu_basic();
        test_mf_stall();
        test_div_by_zero();
        test_signed_neg_dividend();
        test_signed_neg_divisor();
        test_signed_overflow();
        test_divu_ignores_sign();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequencer that issues DIV/DIVU operations from the main control unit onto the shared shift-subtract divider datapath and its controller. It owns the iteration counter that terminates the divider, and handles operand sign conversion and divide-by-zero. It writes quotient/remainder into the LO/HI registers and stalls MFHI/MFLO while a division is in flight. It sits between the multi-cycle control unit and the divider controller/datapath pair.

## Interface
- WIDTH, 32: operand/result width.
- CNT_W, $clog2(WIDTH+1): iteration counter width.

- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- op_valid  in  1  division request from control unit.
- op_signed  in  1  1 = DIV, 0 = DIVU.
- op_a  in  WIDTH  dividend.
- op_b  in  WIDTH  divisor.
- op_ready  out  1  high only in IDLE; accept = op_valid & op_ready.
- mf_req  in  1  MFHI/MFLO in decode.
- stall  out  1  mf_req & busy.
- busy  out  1  state != IDLE.
- div_start  out  1  start pulse to divider controller.
- div_done  out  1  done to divider controller.
- div_dividend  out  WIDTH  magnitude of dividend, registered at accept.
- div_divisor  out  WIDTH  magnitude of divisor, registered at accept.
- div_quotient  in  WIDTH  divider quotient.
- div_remainder  in  WIDTH  divider remainder.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).

## Operation
- States: IDLE, START, RUN, FIX.
- IDLE: op_ready=1. On accept, register the sign flags and the operand magnitudes.
  - If op_b==0, go to FIX with the zero flag set.
  - Otherwise go to START.
- START: div_start=1 for exactly one cycle. Load counter = WIDTH. Go to RUN.
- RUN: counter decrements every cycle. While counter==0, div_done=1 and the next state is FIX. RUN lasts WIDTH+1 cycles: one divider INIT cycle plus WIDTH OPER steps.
- FIX: sample div_quotient/div_remainder, apply sign correction, write lo/hi at the end of the cycle. Go to IDLE.
- Signed (op_signed=1):
  - Magnitudes are two's-complement absolute values, taken as unsigned WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Quotient is negated if sign(a)^sign(b).
  - Remainder is negated if sign(a).
  - Overflow case -2^(WIDTH-1)/-1 gives lo=0x80000000, hi=0 (wrap).
- Divide-by-zero: hi=op_a, lo={WIDTH{1'b1}}. The divider is not started.
- div_done is also driven 1 in IDLE. This flushes a divider controller left in OPER when RST aborts a division, because the divider controller's reset is independent of RST.
- op_valid while busy is ignored (op_ready=0). The requester holds the request until accepted.

## Timing
- Accept at cycle 0. START at cycle 1. RUN at cycles 2..WIDTH+2. FIX at cycle WIDTH+3. hi/lo valid and busy=0 from cycle WIDTH+4, which is 36 for WIDTH=32.
- Divide-by-zero: FIX at cycle 1; hi/lo valid and busy=0 at cycle 2.
- A new accept is possible in the first IDLE cycle, so back-to-back issue interval is WIDTH+4.
- stall is combinational from mf_req and busy. It drops in the same cycle hi/lo become valid.
- Reset values:
  - state=IDLE, counter=0.
  - hi=0, lo=0, div_dividend=0, div_divisor=0.
  - div_start=0, div_done=1, busy=0, op_ready=1, stall=0.
- RST mid-operation returns to IDLE next cycle and discards the partial result. hi/lo are cleared.

## Configuration
- DIV_SIGNED_EN defined: signed handling as above.
- DIV_SIGNED_EN undefined: op_signed is ignored and every operation is DIVU. The sign-fix logic is not instantiated, operands pass through unmodified, and results are written raw.

## Structure
- Package div_seq_pkg:
  - state enum (IDLE, START, RUN, FIX).
  - default WIDTH.
  - divide-by-zero LO constant (all ones).
- Sub-module div_sign_fix: combinational abs/negate of operands and results. Compiled only under DIV_SIGNED_EN.

## Test plan
- DIVU 100/7 -> div_start pulse at cycle 1, div_done at cycle 34, lo=14, hi=2 at cycle 36.
- DIV -7/2 (DIV_SIGNED_EN) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; same op without macro -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> no div_start, hi=5, lo=0xFFFFFFFF at cycle 2.
- mf_req held from cycle 3 -> stall=1 through cycle 35, 0 at cycle 36 with final hi/lo.
- Second op_valid at cycle 5 -> op_ready=0 until cycle 36, accepted at cycle 36, results at cycle 72.
- RST at cycle 10 mid-RUN -> IDLE at cycle 11, hi=lo=0, div_done=1, next DIVU 9/3 -> lo=3, hi=0.
